result_scoreboard: RTL and testbench
====================================

# result_scoreboard

Synthesizable self-checking scoreboard for the 5-stage RISC-V processor. It samples the processor's `Result` stream, compares it against a table of expected values, and awards one point per correct result. It raises `pass` once `NUM_CHECKS` points are reached, and `done` with `pass`=0 on a strict mismatch or a watchdog timeout. It sits beside `Processor` on the board/FPGA top level and replaces manual waveform inspection of point counts.

## Interface
- `WIDTH`, 32: result and expected-value width.
- `NUM_CHECKS`, 20: number of expected-table entries and points required for pass; range 1..256.
- `ORDERED`, 1: 1 = results must match table entries in index order; 0 = any order, each entry matched at most once.
- `STRICT`, 0: 1 = first mismatch ends the run as fail; 0 = mismatches are counted and the run continues.
- `TIMEOUT`, 4096: watchdog limit in cycles without a new point; 0 disables the watchdog.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that begins a run.
- `exp_we`  in  1  expected-table write strobe.
- `exp_addr`  in  $clog2(NUM_CHECKS) (min 1)  write index.
- `exp_data`  in  WIDTH  expected value.
- `res_valid`  in  1  `res_data` holds a new retired result this cycle.
- `res_data`  in  WIDTH  processor result.
- `points`  out  $clog2(NUM_CHECKS+1)  correct results so far.
- `errors`  out  8  mismatch count, saturating at 255.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in PASS, FAIL or TIMEOUT.
- `pass`  out  1  high in PASS only.

## Operation
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. Reset value is IDLE, with all outputs 0, match bitmap cleared and watchdog cleared. Table contents are not reset.
- IDLE or any terminal state, `start`=1 -> RUN. Entry clears `points`, `errors`, the match bitmap, the order index and the watchdog.
- `start` during RUN restarts the run with the same clears and stays in RUN.
- `exp_we` is honoured only outside RUN. During RUN it is ignored.
- Each RUN cycle with `res_valid`=1 is handled by mode:
  - ORDERED=1: compare against entry[idx]. On equal, `points`+1 and idx+1.
  - ORDERED=0: compare against all unmatched entries. On any hit, the lowest matching index has its bitmap bit set and `points`+1.
  - No hit: `errors`+1 (saturating). With STRICT=1, go to FAIL.
- `points` = NUM_CHECKS -> PASS.
- Watchdog increments every RUN cycle and clears on each point. Reaching TIMEOUT (when non-zero) -> TIMEOUT.
- Terminal states hold all outputs until `start` or reset. `res_valid` is ignored outside RUN.
- Reset mid-run aborts immediately to IDLE.

## Timing
- A sample taken on edge N updates `points`/`errors` after edge N, visible in cycle N+1.
- Final point: `points`=NUM_CHECKS, `done`=1 and `pass`=1 all together in cycle N+1. There is no extra cycle.
- Strict mismatch: `done`=1, `pass`=0 in cycle N+1, and `errors` already includes the mismatch.
- Priority within a single cycle, highest first: reset, `start`, final match, mismatch/fail, timeout. A final match in the same cycle as the watchdog limit gives PASS.
- Sustained `res_valid` every cycle is supported at full rate. There is no backpressure.
- Values equal to an already-matched entry (ORDERED=0) count as mismatches.

## Structure
- Package `scoreboard_pkg` holds:
  - the state enum;
  - the `ERR_W`=8 constant;
  - a `clog2_min1` helper function for index widths.
- Sub-module `sb_match_table` holds:
  - the NUM_CHECKS×WIDTH expected storage and its write port;
  - the match bitmap;
  - the ordered/any-order comparator, with outputs `hit` and `hit_idx` (lowest index).
- Top level holds the FSM, counters and watchdog.

## Test plan
- Load table 1..20, start, drive 1..20 in order one per cycle -> `points`=20 and `pass`=1 one cycle after the last sample; `errors`=0.
- ORDERED=1, STRICT=0: drive 1,2,99,3..20 -> `pass`=1 and `errors`=1. Same stimulus with STRICT=1 -> FAIL in the cycle after 99, `points`=2, `errors`=1.
- ORDERED=0: drive 20 down to 1, then a repeated 5 -> PASS after the 20th distinct value. A second run repeating 5 twice early -> `errors`=1 and `points` counts the 5 only once.
- TIMEOUT=50: drive 1..3, then idle -> TIMEOUT exactly 50 cycles after the third sample's cycle; `points`=3, `done`=1, `pass`=0.
- Final match on the same cycle the watchdog expires -> PASS. 300 mismatches with STRICT=0 -> `errors` saturates at 255.
- Assert `reset` mid-run at `points`=7 -> all outputs 0 asynchronously. Release, start, drive 1..20 -> PASS, proving the table is retained.

Source files
------------

// File: rtl/result_scoreboard_pkg.sv
// Shared types and helpers for the result scoreboard: FSM state encoding,
// error-counter width and an index-width helper that never returns zero.
package scoreboard_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } sb_state_e;

    localparam int ERR_W = 8;

    // Width needed to index n entries, at least one bit so a 1-entry table still has an address.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/result_scoreboard_if.sv
// Bus between the scoreboard and its driver: table load port, processor
// result stream and the run status outputs.
interface result_scoreboard_if
    import scoreboard_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_CHECKS = 20
);
    localparam int IDX_W = clog2_min1(NUM_CHECKS);
    localparam int PTS_W = $clog2(NUM_CHECKS + 1);

    logic             start;
    logic             exp_we;
    logic [IDX_W-1:0] exp_addr;
    logic [WIDTH-1:0] exp_data;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic [PTS_W-1:0] points;
    logic [ERR_W-1:0] errors;
    logic             busy;
    logic             done;
    logic             pass;

    modport master (
        output start, exp_we, exp_addr, exp_data, res_valid, res_data,
        input  points, errors, busy, done, pass
    );

    modport slave (
        input  start, exp_we, exp_addr, exp_data, res_valid, res_data,
        output points, errors, busy, done, pass
    );

endinterface

// File: rtl/result_scoreboard_match_table.sv
// Expected-value storage, match bitmap and comparator. Reports whether the
// current result hits and, in any-order mode, the lowest unmatched entry hit.
module sb_match_table
    import scoreboard_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_CHECKS = 20,
    parameter int ORDERED    = 1,
    parameter int IDX_W      = clog2_min1(NUM_CHECKS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             clr,
    input  logic             mark_en,
    input  logic [IDX_W-1:0] mark_idx,
    input  logic [WIDTH-1:0] cmp_data,
    input  logic [IDX_W-1:0] ord_idx,
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx
);

    logic [WIDTH-1:0]      mem_q [NUM_CHECKS];
    logic [WIDTH-1:0]      mem_d [NUM_CHECKS];
    logic [NUM_CHECKS-1:0] map_q;
    logic [NUM_CHECKS-1:0] map_d;
    logic                  any_hit;
    logic [IDX_W-1:0]      any_idx;
    logic                  ord_hit;

    always_comb begin
        mem_d = mem_q;
        if (we && (int'(waddr) < NUM_CHECKS)) begin
            mem_d[waddr] = wdata;
        end
        map_d = map_q;
        if (clr) begin
            map_d = '0;
        end else if (mark_en) begin
            map_d[mark_idx] = 1'b1;
        end
    end

    // Descending scan so the last assignment left standing is the lowest index.
    always_comb begin
        any_hit = 1'b0;
        any_idx = '0;
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            if (!map_q[i] && (mem_q[i] == cmp_data)) begin
                any_hit = 1'b1;
                any_idx = IDX_W'(i);
            end
        end
        ord_hit = (int'(ord_idx) < NUM_CHECKS) && (mem_q[ord_idx] == cmp_data);
        hit     = (ORDERED != 0) ? ord_hit : any_hit;
        hit_idx = (ORDERED != 0) ? ord_idx : any_idx;
    end

    // Table contents survive reset so a board reset does not force a reload.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            map_q <= '0;
        end else begin
            map_q <= map_d;
        end
    end

endmodule

// File: rtl/result_scoreboard.sv
// Self-checking scoreboard beside the processor: scores the Result stream
// against a loaded table and reports pass, mismatch fail or watchdog timeout.
//
// state      | meaning
// ST_IDLE    | after reset, waiting for start
// ST_RUN     | sampling results, counting points/errors, watchdog running
// ST_PASS    | NUM_CHECKS points reached
// ST_FAIL    | mismatch seen with STRICT set
// ST_TIMEOUT | watchdog expired without a new point
module result_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_CHECKS = 20,
    parameter int ORDERED    = 1,
    parameter int STRICT     = 0,
    parameter int TIMEOUT    = 4096
) (
    input logic                clk,
    input logic                reset,
    result_scoreboard_if.slave bus
);

    localparam int IDX_W     = clog2_min1(NUM_CHECKS);
    localparam int PTS_W     = $clog2(NUM_CHECKS + 1);
    localparam int WD_W      = clog2_min1(TIMEOUT + 1);
    localparam int WD_LOAD_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [WD_W-1:0]  WD_LOAD   = WD_W'(WD_LOAD_I);
    localparam logic [PTS_W-1:0] PTS_LAST  = PTS_W'(NUM_CHECKS - 1);
    localparam bit               WD_EN     = (TIMEOUT > 0);
    localparam bit               STRICT_EN = (STRICT != 0);

    sb_state_e        state_q, state_d;
    logic [PTS_W-1:0] points_q, points_d;
    logic [ERR_W-1:0] errors_q, errors_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             clr_map;
    logic             mark_en;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             in_run;

    assign in_run = (state_q == ST_RUN);

    sb_match_table #(
        .WIDTH      (WIDTH),
        .NUM_CHECKS (NUM_CHECKS),
        .ORDERED    (ORDERED),
        .IDX_W      (IDX_W)
    ) u_match_table (
        .clk      (clk),
        .reset    (reset),
        .we       (bus.exp_we && !in_run),
        .waddr    (bus.exp_addr),
        .wdata    (bus.exp_data),
        .clr      (clr_map),
        .mark_en  (mark_en),
        .mark_idx (hit_idx),
        .cmp_data (bus.res_data),
        .ord_idx  (points_q[IDX_W-1:0]),
        .hit      (hit),
        .hit_idx  (hit_idx)
    );

    // Watchdog is a down-counter reloaded on every point; expiry is terminal count zero.
    always_comb begin
        state_d  = state_q;
        points_d = points_q;
        errors_d = errors_q;
        wd_d     = wd_q;
        clr_map  = 1'b0;
        mark_en  = 1'b0;
        if (bus.start) begin
            state_d  = ST_RUN;
            points_d = '0;
            errors_d = '0;
            wd_d     = WD_LOAD;
            clr_map  = 1'b1;
        end else if (in_run) begin
            if (bus.res_valid && hit) begin
                mark_en  = 1'b1;
                points_d = points_q + PTS_W'(1);
                wd_d     = WD_LOAD;
                if (points_q == PTS_LAST) begin
                    state_d = ST_PASS;
                end
            end else begin
                if (bus.res_valid) begin
                    if (errors_q != '1) begin
                        errors_d = errors_q + ERR_W'(1);
                    end
                    if (STRICT_EN) begin
                        state_d = ST_FAIL;
                    end
                end
                if (WD_EN && (state_d == ST_RUN)) begin
                    if (wd_q == '0) begin
                        state_d = ST_TIMEOUT;
                    end else begin
                        wd_d = wd_q - WD_W'(1);
                    end
                end
            end
        end
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
        pass_d = (state_d == ST_PASS);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            points_q <= '0;
            errors_q <= '0;
            wd_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            points_q <= points_d;
            errors_q <= errors_d;
            wd_q     <= wd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign bus.points = points_q;
    assign bus.errors = errors_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.pass   = pass_q;

endmodule

// File: tb/tb_result_scoreboard.sv
// Bench for result_scoreboard: three configurations share one stimulus stream,
// each cycle's expected outputs are queued from a behavioural model and checked.
module tb_result_scoreboard;

    localparam int N = 20;
    localparam int ORD_P [3] = '{1, 1, 0};
    localparam int STR_P [3] = '{0, 1, 0};
    localparam int TO_P  [3] = '{50, 0, 0};

    logic        clk;
    logic        reset;
    logic        start;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        res_valid;
    logic [31:0] res_data;
    logic [15:0] obs [3];

    int n_check = 0;
    int n_pass  = 0;
    int cyc     = 0;

    int          m_st  [3];
    int          m_pts [3];
    int          m_err [3];
    int          m_wd  [3];
    logic [20:0] m_seen[3];
    logic [15:0] sbq[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        result_scoreboard_if #(.WIDTH(32), .NUM_CHECKS(N)) bus ();
        assign bus.start     = start;
        assign bus.exp_we    = exp_we;
        assign bus.exp_addr  = exp_addr;
        assign bus.exp_data  = exp_data;
        assign bus.res_valid = res_valid;
        assign bus.res_data  = res_data;
        assign obs[g] = {bus.points, bus.errors, bus.busy, bus.done, bus.pass};
        result_scoreboard #(
            .WIDTH(32), .NUM_CHECKS(N), .ORDERED(ORD_P[g]),
            .STRICT(STR_P[g]), .TIMEOUT(TO_P[g])
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] f_pts(input int k);  return 32'(obs[k][15:11]); endfunction
    function automatic logic [31:0] f_err(input int k);  return 32'(obs[k][10:3]);  endfunction
    function automatic logic [31:0] f_busy(input int k); return 32'(obs[k][2]);     endfunction
    function automatic logic [31:0] f_done(input int k); return 32'(obs[k][1]);     endfunction
    function automatic logic [31:0] f_pass(input int k); return 32'(obs[k][0]);     endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_check = n_check + 1;
        assert (got === want) n_pass = n_pass + 1;
        else $error("FAIL %s got=%0d expected=%0d", tag, got, want);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_st[k] = 0; m_pts[k] = 0; m_err[k] = 0; m_wd[k] = 0; m_seen[k] = '0;
        end
    endtask

    // Table entry i holds i+1, so a value scores if it is the next in order
    // (ordered) or an in-range value not yet seen (any order).
    task automatic model_cycle(input int k, input bit s, input bit v, input int d);
        bit h;
        if (s) begin
            m_st[k] = 1; m_pts[k] = 0; m_err[k] = 0; m_wd[k] = 0; m_seen[k] = '0;
        end else if (m_st[k] == 1) begin
            if (ORD_P[k] != 0) h = v && (d == m_pts[k] + 1);
            else               h = v && (d >= 1) && (d <= N) && !m_seen[k][d];
            if (h) begin
                m_pts[k] = m_pts[k] + 1;
                if (ORD_P[k] == 0) m_seen[k][d] = 1'b1;
                m_wd[k] = 0;
                if (m_pts[k] == N) m_st[k] = 2;
            end else begin
                if (v) begin
                    if (m_err[k] < 255) m_err[k] = m_err[k] + 1;
                    if (STR_P[k] != 0) m_st[k] = 3;
                end
                if (m_st[k] == 1 && TO_P[k] != 0) begin
                    m_wd[k] = m_wd[k] + 1;
                    if (m_wd[k] == TO_P[k]) m_st[k] = 4;
                end
            end
        end
    endtask

    function automatic logic [15:0] exp_vec(input int k);
        return {5'(m_pts[k]), 8'(m_err[k]), m_st[k] == 1, m_st[k] >= 2, m_st[k] == 2};
    endfunction

    // Called at a falling edge: drive one cycle, queue expectations, check after the rising edge.
    task automatic step(input bit s, input bit v, input int d,
                        input bit w = 1'b0, input int wa = 0, input int wdat = 0);
        logic [15:0] e;
        start = s; res_valid = v; res_data = 32'(d);
        exp_we = w; exp_addr = 5'(wa); exp_data = 32'(wdat);
        for (int k = 0; k < 3; k++) begin
            model_cycle(k, s, v, d);
            sbq.push_back(exp_vec(k));
        end
        @(posedge clk);
        @(negedge clk);
        cyc = cyc + 1;
        start = 1'b0; res_valid = 1'b0; exp_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e = sbq.pop_front();
            n_check = n_check + 1;
            assert (obs[k] === e) n_pass = n_pass + 1;
            else $error("FAIL sb_dut%0d cyc=%0d got pts=%0d err=%0d bdp=%b expected pts=%0d err=%0d bdp=%b",
                        k, cyc, obs[k][15:11], obs[k][10:3], obs[k][2:0], e[15:11], e[10:3], e[2:0]);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
        res_valid = 1'b0; res_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("reset_outputs_dut%0d", k), 32'(obs[k]), 0);
        reset = 1'b1;

        for (int i = 0; i < N; i++) step(0, 0, 0, 1, i, i + 1);

        // In-order run
        step(1, 0, 0);
        for (int v = 1; v < N; v++) step(0, 1, v);
        chk("r1_a_pts19", f_pts(0), 19);
        chk("r1_a_nopass", f_pass(0), 0);
        step(0, 1, N);
        chk("r1_a_pts", f_pts(0), 20);
        chk("r1_a_pass", f_pass(0), 1);
        chk("r1_a_err", f_err(0), 0);
        chk("r1_c_pass", f_pass(2), 1);

        // One wrong value; table write attempted while running must be ignored
        step(1, 0, 0);
        step(0, 1, 1, 1, 2, 500);
        step(0, 1, 2);
        step(0, 1, 99);
        chk("r2_b_done", f_done(1), 1);
        chk("r2_b_pass", f_pass(1), 0);
        chk("r2_b_pts", f_pts(1), 2);
        chk("r2_b_err", f_err(1), 1);
        for (int v = 3; v <= N; v++) step(0, 1, v);
        chk("r2_a_pass", f_pass(0), 1);
        chk("r2_a_err", f_err(0), 1);

        // Reverse order for the any-order instance
        step(1, 0, 0);
        for (int v = N; v >= 1; v--) step(0, 1, v);
        chk("r3_c_pass", f_pass(2), 1);
        chk("r3_c_pts", f_pts(2), 20);
        step(0, 1, 5);
        chk("r3_c_hold_err", f_err(2), 0);

        // Restart mid-run (sample in start cycle ignored), then repeated 5
        step(1, 0, 0);
        for (int v = 1; v <= 3; v++) step(0, 1, v);
        step(1, 1, 4);
        for (int v = 1; v <= 5; v++) step(0, 1, v);
        step(0, 1, 5);
        chk("r4_c_pts5", f_pts(2), 5);
        chk("r4_c_err1", f_err(2), 1);
        for (int v = 6; v <= N; v++) step(0, 1, v);
        chk("r4_c_pass", f_pass(2), 1);
        chk("r4_c_err", f_err(2), 1);

        // Watchdog expiry 50 cycles after the last point
        step(1, 0, 0);
        for (int v = 1; v <= 3; v++) step(0, 1, v);
        repeat (49) step(0, 0, 0);
        chk("r5_a_not_yet", f_done(0), 0);
        chk("r5_a_busy", f_busy(0), 1);
        step(0, 0, 0);
        chk("r5_a_done", f_done(0), 1);
        chk("r5_a_pass", f_pass(0), 0);
        chk("r5_a_pts", f_pts(0), 3);
        chk("r5_c_no_wd", f_busy(2), 1);

        // Final match on the watchdog limit cycle
        step(1, 0, 0);
        for (int v = 1; v < N; v++) step(0, 1, v);
        repeat (49) step(0, 0, 0);
        step(0, 1, N);
        chk("r6_a_pass", f_pass(0), 1);
        chk("r6_a_pts", f_pts(0), 20);

        // Error counter saturation
        step(1, 0, 0);
        repeat (300) step(0, 1, 1000);
        chk("r7_c_err_sat", f_err(2), 255);
        chk("r7_c_busy", f_busy(2), 1);
        chk("r7_a_err", f_err(0), 50);
        chk("r7_a_done", f_done(0), 1);

        // Asynchronous reset mid-run, then table retained
        step(1, 0, 0);
        for (int v = 1; v <= 7; v++) step(0, 1, v);
        chk("r8_a_pts7", f_pts(0), 7);
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("r8_async_rst_dut%0d", k), 32'(obs[k]), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(1, 0, 0);
        for (int v = 1; v <= N; v++) step(0, 1, v);
        chk("r8_a_pass", f_pass(0), 1);
        chk("r8_c_pass", f_pass(2), 1);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
